alu_mp_seq: RTL and testbench

- Multi-precision sequencer that drives the 8-bit combinational ALU as its initiator.
- Accepts one NWORDS×8-bit operation over a valid/ready request port.
- Issues one ALU operation per word per cycle, chaining SC_OUT back into SC_IN through a carry register, and assembles the wide result.
- Returns result plus carry/zero flags over a valid/ready response port.
- Sits between the control unit and the ALU, replacing direct ALU drive for 16-bit arithmetic and shifts.

---
 rtl/alu_mp_seq.sv | 147 ++++++++++++++
 tb/tb_alu_mp_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mp_seq.sv
// Multi-precision sequencer: runs one NWORDS x 8-bit op through the 8-bit ALU, one word per cycle.
// Latency NWORDS+1 edges from accept to RSP_VALID; the response is held until RSP_READY.
module alu_mp_seq #(
  parameter int NWORDS = 2
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [2:0]            REQ_OP,
  input  logic [8*NWORDS-1:0]   REQ_A,
  input  logic [8*NWORDS-1:0]   REQ_B,
  input  logic                  REQ_CIN,
  output logic [7:0]            ALU_A,
  output logic [7:0]            ALU_B,
  output logic [1:0]            ALU_OP,
  output logic [1:0]            ALU_FUNCT,
  output logic                  ALU_SC_IN,
  input  logic [7:0]            ALU_OUT,
  input  logic                  ALU_SC_OUT,
  input  logic                  ALU_ZERO,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [8*NWORDS-1:0]   RSP_RESULT,
  output logic                  RSP_CARRY,
  output logic                  RSP_ZERO,
  output logic                  RSP_ERR
);

  localparam int W  = 8 * NWORDS;
  localparam int SW = $clog2(NWORDS);
  localparam logic [SW-1:0] LAST = SW'(NWORDS - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_LSH = 3'd1;
  localparam logic [2:0] OP_RSH = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;

  // ALU {OP,FUNCT} encodings; 0 is reserved for "no operation driven".
  localparam logic [3:0] K_ADD = 4'b0100;
  localparam logic [3:0] K_LSH = 4'b1000;
  localparam logic [3:0] K_RSH = 4'b1001;
  localparam logic [3:0] K_XOR = 4'b1100;
  localparam logic [3:0] K_AND = 4'b1101;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q, res_q, res_nxt;
  logic [2:0]      op_q;
  logic            carry_q, zero_q, carry_nxt;
  logic [SW-1:0]   step_q, idx;
  logic            accept, op_legal, last_step, chain_carry;

  assign REQ_READY   = (state == IDLE) && !Reset;
  assign accept      = REQ_VALID && REQ_READY;
  assign op_legal    = (REQ_OP <= OP_AND);
  assign last_step   = (step_q == LAST);
  assign chain_carry = (op_q == OP_ADD) || (op_q == OP_LSH) || (op_q == OP_RSH);
  // Right shifts walk MSW first so the shifted-out bit flows downward.
  assign idx         = (op_q == OP_RSH) ? (LAST - step_q) : step_q;
  assign RSP_VALID   = (state == DONE);

  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ALU_A     = '0;
    ALU_B     = '0;
    ALU_SC_IN = 1'b0;
    ALU_OP    = 2'b00;
    ALU_FUNCT = 2'b00;
    res_nxt   = res_q;
    res_nxt[{idx, 3'b000} +: 8] = ALU_OUT;
    carry_nxt = chain_carry ? ALU_SC_OUT : 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = op_legal ? RUN : DONE;
      RUN: begin
        ALU_A     = a_q[{idx, 3'b000} +: 8];
        ALU_B     = b_q[{idx, 3'b000} +: 8];
        ALU_SC_IN = carry_q;
        case (op_q)
          OP_ADD:  {ALU_OP, ALU_FUNCT} = K_ADD;
          OP_LSH:  {ALU_OP, ALU_FUNCT} = K_LSH;
          OP_RSH:  {ALU_OP, ALU_FUNCT} = K_RSH;
          OP_XOR:  {ALU_OP, ALU_FUNCT} = K_XOR;
          OP_AND:  {ALU_OP, ALU_FUNCT} = K_AND;
          default: {ALU_OP, ALU_FUNCT} = 4'b0000;
        endcase
        if (last_step) state_nxt = DONE;
      end
      DONE: if (RSP_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      op_q       <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      step_q     <= '0;
      RSP_RESULT <= '0;
      RSP_CARRY  <= 1'b0;
      RSP_ZERO   <= 1'b0;
      RSP_ERR    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q     <= REQ_A;
          b_q     <= REQ_B;
          op_q    <= REQ_OP;
          carry_q <= REQ_CIN;
          zero_q  <= 1'b1;
          step_q  <= '0;
          if (!op_legal) begin
            RSP_RESULT <= '0;
            RSP_CARRY  <= 1'b0;
            RSP_ZERO   <= 1'b1;
            RSP_ERR    <= 1'b1;
          end
        end
        RUN: begin
          res_q   <= res_nxt;
          carry_q <= carry_nxt;
          zero_q  <= zero_q & ALU_ZERO;
          step_q  <= step_q + 1'b1;
          if (last_step) begin
            RSP_RESULT <= res_nxt;
            RSP_CARRY  <= carry_nxt;
            RSP_ZERO   <= zero_q & ALU_ZERO;
            RSP_ERR    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mp_seq.sv
// Directed bench for alu_mp_seq with a behavioural 8-bit ALU closing the loop.
module tb_alu_mp_seq;

  localparam int NWORDS = 2;
  localparam int W = 8 * NWORDS;

  logic         CLK = 1'b0;
  logic         Reset;
  logic         REQ_VALID, REQ_READY, REQ_CIN;
  logic [2:0]   REQ_OP;
  logic [W-1:0] REQ_A, REQ_B;
  logic [7:0]   ALU_A, ALU_B, alu_out;
  logic [1:0]   ALU_OP, ALU_FUNCT;
  logic         ALU_SC_IN, alu_sc_out, alu_zero;
  logic         RSP_VALID, RSP_READY, RSP_CARRY, RSP_ZERO, RSP_ERR;
  logic [W-1:0] RSP_RESULT;
  logic [3:0]   code;

  int n_checks = 0;
  int n_fail   = 0;
  int steps;
  logic [7:0] tr_a [0:7];
  logic       tr_sc[0:7];
  logic [3:0] tr_code[0:7];

  always #5 CLK = ~CLK;

  alu_mp_seq #(.NWORDS(NWORDS)) dut (
    .CLK(CLK), .Reset(Reset),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_CIN(REQ_CIN),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .ALU_FUNCT(ALU_FUNCT),
    .ALU_SC_IN(ALU_SC_IN), .ALU_OUT(alu_out), .ALU_SC_OUT(alu_sc_out), .ALU_ZERO(alu_zero),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RESULT(RSP_RESULT),
    .RSP_CARRY(RSP_CARRY), .RSP_ZERO(RSP_ZERO), .RSP_ERR(RSP_ERR)
  );

  // Reference 8-bit ALU: ADD=0100 LSH=1000 RSH=1001 XOR=1100 AND=1101.
  assign code = {ALU_OP, ALU_FUNCT};
  always_comb begin
    alu_out    = 8'h00;
    alu_sc_out = 1'b0;
    case (code)
      4'b0100: {alu_sc_out, alu_out} = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'h00, ALU_SC_IN};
      4'b1000: begin alu_out = {ALU_A[6:0], ALU_SC_IN}; alu_sc_out = ALU_A[7]; end
      4'b1001: begin alu_out = {ALU_SC_IN, ALU_A[7:1]}; alu_sc_out = ALU_A[0]; end
      4'b1100: alu_out = ALU_A ^ ALU_B;
      4'b1101: alu_out = ALU_A & ALU_B;
      default: ;
    endcase
    alu_zero = (alu_out == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin);
    @(negedge CLK);
    REQ_OP = op; REQ_A = a; REQ_B = b; REQ_CIN = cin; REQ_VALID = 1'b1;
    check("req_ready_at_issue", 32'(REQ_READY), 32'd1);
    @(posedge CLK);
  endtask

  // Records ALU drive each cycle until RSP_VALID, bounded.
  task automatic collect(input string tag, input int exp_steps);
    bit seen = 0;
    steps = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      REQ_VALID = 1'b0;
      if (RSP_VALID) begin seen = 1; break; end
      if (steps < 8) begin
        tr_a[steps] = ALU_A; tr_sc[steps] = ALU_SC_IN; tr_code[steps] = code;
      end
      steps++;
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_latency"}, 32'(steps), 32'(exp_steps));
  endtask

  task automatic check_rsp(input string tag, input logic [W-1:0] res, input logic c,
                           input logic z, input logic e);
    check({tag, "_result"}, 32'(RSP_RESULT), 32'(res));
    check({tag, "_carry"},  32'(RSP_CARRY),  32'(c));
    check({tag, "_zero"},   32'(RSP_ZERO),   32'(z));
    check({tag, "_err"},    32'(RSP_ERR),    32'(e));
  endtask

  task automatic ack(input string tag);
    RSP_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RSP_READY = 1'b0;
    check({tag, "_valid_drop"}, 32'(RSP_VALID), 32'd0);
    check({tag, "_idle_ready"}, 32'(REQ_READY), 32'd1);
  endtask

  initial begin
    Reset = 1'b1; REQ_VALID = 1'b0; REQ_OP = '0; REQ_A = '0; REQ_B = '0; REQ_CIN = 1'b0;
    RSP_READY = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_valid",  32'(RSP_VALID),  32'd0);
    check("rst_ready",  32'(REQ_READY),  32'd0);
    check("rst_result", 32'(RSP_RESULT), 32'd0);
    check("rst_flags",  32'({RSP_CARRY, RSP_ZERO, RSP_ERR}), 32'd0);
    check("rst_alu",    32'({code, ALU_A, ALU_B, ALU_SC_IN}), 32'd0);
    Reset = 1'b0;

    // ADD with byte carry propagation
    issue(3'd0, 16'h12FF, 16'h0001, 1'b0);
    collect("add1", 2);
    check("add1_lsw_a",   32'(tr_a[0]), 32'hFF);
    check("add1_lsw_sc",  32'(tr_sc[0]), 32'd0);
    check("add1_msw_sc",  32'(tr_sc[1]), 32'd1);
    check("add1_code",    32'(tr_code[0]), 32'h4);
    check_rsp("add1", 16'h1300, 1'b0, 1'b0, 1'b0);
    ack("add1");

    issue(3'd0, 16'hFFFF, 16'h0001, 1'b0);
    collect("add2", 2);
    check_rsp("add2", 16'h0000, 1'b1, 1'b1, 1'b0);
    ack("add2");

    issue(3'd1, 16'hB380, 16'h0000, 1'b1);
    collect("lsh", 2);
    check_rsp("lsh", 16'h6701, 1'b1, 1'b0, 1'b0);
    ack("lsh");

    issue(3'd2, 16'h0181, 16'h0000, 1'b0);
    collect("rsh", 2);
    check("rsh_first_a",  32'(tr_a[0]), 32'h01);
    check("rsh_second_a", 32'(tr_a[1]), 32'h81);
    check_rsp("rsh", 16'h00C0, 1'b1, 1'b0, 1'b0);
    ack("rsh");

    issue(3'd3, 16'hA5A5, 16'hA5A5, 1'b1);
    collect("xor", 2);
    check_rsp("xor", 16'h0000, 1'b0, 1'b1, 1'b0);
    ack("xor");

    issue(3'd4, 16'hF00F, 16'h0FF0, 1'b0);
    collect("and", 2);
    check_rsp("and", 16'h0000, 1'b0, 1'b1, 1'b0);
    ack("and");

    // Backpressure in DONE with a new request waiting
    issue(3'd0, 16'h1234, 16'h0101, 1'b0);
    collect("bp", 2);
    REQ_VALID = 1'b1; REQ_OP = 3'd3; REQ_A = 16'h00FF; REQ_B = 16'h0F0F; REQ_CIN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("bp_hold_valid",  32'(RSP_VALID), 32'd1);
      check("bp_hold_result", 32'(RSP_RESULT), 32'h1335);
      check("bp_hold_ready",  32'(REQ_READY), 32'd0);
    end
    RSP_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RSP_READY = 1'b0;
    check("bp_idle_valid",  32'(RSP_VALID), 32'd0);
    check("bp_idle_ready",  32'(REQ_READY), 32'd1);
    check("bp_idle_alu",    32'(code), 32'd0);
    check("bp_kept_result", 32'(RSP_RESULT), 32'h1335);
    @(posedge CLK);
    collect("b2b", 2);
    check("b2b_first_a", 32'(tr_a[0]), 32'hFF);
    check("b2b_code",    32'(tr_code[0]), 32'hC);
    check_rsp("b2b", 16'h0FF0, 1'b0, 1'b0, 1'b0);
    ack("b2b");

    // Reset in RUN step 0
    issue(3'd0, 16'h1111, 16'h2222, 1'b0);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    check("rr_in_run", 32'(code), 32'h4);
    Reset = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    check("rr_valid",  32'(RSP_VALID), 32'd0);
    check("rr_alu",    32'(code), 32'd0);
    check("rr_result", 32'(RSP_RESULT), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("rr_no_valid", 32'(RSP_VALID), 32'd0);
      check("rr_ready",    32'(REQ_READY), 32'd1);
    end

    // Illegal opcode
    issue(3'd6, 16'hFFFF, 16'hFFFF, 1'b1);
    collect("ill", 0);
    check("ill_alu", 32'(code), 32'd0);
    check_rsp("ill", 16'h0000, 1'b0, 1'b1, 1'b1);
    ack("ill");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
